// File: rtl/msk_arb_pkg.sv
// Shared types and constants for the masked-unit share arbiter.
// The optional round-robin tie-break is enabled with the MSKARB_RR_EN macro.
package msk_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  // Mux select encoding; the select is a public control value, never a share.
  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

  typedef struct packed {
    logic valid;
    logic id;     // 1 = requester A
  } tag_t;

  localparam tag_t TAG_NONE = '{valid: 1'b0, id: 1'b0};

  // Pick the GNT state for the given pending requests; tie_a decides a tie.
  function automatic state_t arb_pick(input logic av, input logic bv, input logic tie_a);
    state_t pick;
    if (av && bv) begin
      pick = tie_a ? GNT_A : GNT_B;
    end else if (av) begin
      pick = GNT_A;
    end else if (bv) begin
      pick = GNT_B;
    end else begin
      pick = IDLE;
    end
    return pick;
  endfunction

endpackage

// File: rtl/msk_mux2.sv
// Masked 2:1 mux gadget: selects whole share vectors with a public select.
// Each share lane is muxed independently so shares are never combined.
module msk_mux2
  import msk_arb_pkg::*;
#(
  parameter int d     = 2,
  parameter int count = 8
) (
  input  logic               sel,
  input  logic [count*d-1:0] in_a,
  input  logic [count*d-1:0] in_b,
  output logic [count*d-1:0] y
);

  // Per-share lane select
  always_comb begin
    y = {(count*d){1'b0}};
    for (int i = 0; i < d; i++) begin
      if (sel == SEL_A) begin
        y[i*count +: count] = in_a[i*count +: count];
      end else begin
        y[i*count +: count] = in_b[i*count +: count];
      end
    end
  end

endmodule

// File: rtl/msk_tag_pipe.sv
// Tag shift register that mirrors the shared unit's fixed latency.
// Each stage carries {valid, id}; synchronous clear discards in-flight tags.
module msk_tag_pipe
  import msk_arb_pkg::*;
#(
  parameter int LAT = 4
) (
  input  logic clk,
  input  logic syn_rst,
  input  tag_t tag_in,
  output tag_t tag_out,
  output logic any_valid
);

  tag_t pipe_r [LAT];

  // Shift tags one stage per cycle, clearing all stages on reset
  always_ff @(posedge clk) begin
    if (syn_rst) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_r[i] <= TAG_NONE;
      end
    end else begin
      pipe_r[0] <= tag_in;
      for (int i = 1; i < LAT; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign tag_out = pipe_r[LAT-1];

  // Any stage holding a live tag keeps the arbiter busy
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      any_valid = any_valid | pipe_r[i].valid;
    end
  end

endmodule

// File: rtl/msk_share_arbiter.sv
// Two-requester arbiter/sequencer for a shared, fully pipelined masked unit.
// Holds the grant across bursts, drives the public mux select and routes
// returning result-valid flags by tag. Only control signals are unmasked.
// Macro MSKARB_RR_EN: round-robin tie-break (default: A wins ties).
module msk_share_arbiter
  import msk_arb_pkg::*;
#(
  parameter int d     = 2,
  parameter int count = 8,
  parameter int LAT   = 4
) (
  input  logic               clk,
  input  logic               syn_rst,
  input  logic               a_valid,
  input  logic               b_valid,
  input  logic               a_last,
  input  logic               b_last,
  input  logic [count*d-1:0] a_data,
  input  logic [count*d-1:0] b_data,
  output logic               a_ready,
  output logic               b_ready,
  output logic [count*d-1:0] unit_in,
  output logic               unit_valid,
  input  logic [count*d-1:0] unit_out,
  output logic [count*d-1:0] res_data,
  output logic               a_res_valid,
  output logic               b_res_valid,
  output logic               busy
);

  localparam int W = count * d;

  state_t     state_r;
  state_t     next_s;
  logic       a_ready_r;
  logic       b_ready_r;
  logic       a_xfer_s;
  logic       b_xfer_s;
  logic       burst_done_s;
  logic       tie_a_s;
  logic       sel_s;
  logic [W-1:0] mux_s;
  tag_t       tag_in_s;
  tag_t       tag_out_s;
  logic       tags_busy_s;

  assign a_xfer_s     = a_ready_r & a_valid;
  assign b_xfer_s     = b_ready_r & b_valid;
  assign burst_done_s = (a_xfer_s & a_last) | (b_xfer_s & b_last);

`ifdef MSKARB_RR_EN
  logic ptr_r;

  // Round-robin pointer: after a completed burst, favour the other requester
  always_ff @(posedge clk) begin
    if (syn_rst) begin
      ptr_r <= SEL_A;
    end else if (burst_done_s) begin
      ptr_r <= a_xfer_s ? SEL_B : SEL_A;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign tie_a_s = (ptr_r == SEL_A);
`else
  assign tie_a_s = 1'b1;
`endif

  // Next grant: arbitrate from IDLE, or at a last beat excluding its owner
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        next_s = arb_pick(a_valid, b_valid, tie_a_s);
      end
      GNT_A: begin
        if (a_valid && a_last) begin
          next_s = arb_pick(1'b0, b_valid, tie_a_s);
        end else begin
          next_s = GNT_A;
        end
      end
      GNT_B: begin
        if (b_valid && b_last) begin
          next_s = arb_pick(a_valid, 1'b0, tie_a_s);
        end else begin
          next_s = GNT_B;
        end
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // Grant FSM with registered ready flags decoded from the next state
  always_ff @(posedge clk) begin
    if (syn_rst) begin
      state_r   <= IDLE;
      a_ready_r <= 1'b0;
      b_ready_r <= 1'b0;
    end else begin
      state_r   <= next_s;
      a_ready_r <= (next_s == GNT_A);
      b_ready_r <= (next_s == GNT_B);
    end
  end

  assign a_ready    = a_ready_r;
  assign b_ready    = b_ready_r;
  assign unit_valid = a_xfer_s | b_xfer_s;
  assign sel_s      = (state_r == GNT_A) ? SEL_A : SEL_B;

  msk_mux2 #(
    .d     (d),
    .count (count)
  ) u_mux (
    .sel  (sel_s),
    .in_a (a_data),
    .in_b (b_data),
    .y    (mux_s)
  );

  // Idle cycles present zeros so stale shares never toggle the unit
  assign unit_in = unit_valid ? mux_s : {W{1'b0}};

  assign tag_in_s = '{valid: unit_valid, id: (state_r == GNT_A)};

  msk_tag_pipe #(
    .LAT (LAT)
  ) u_tags (
    .clk       (clk),
    .syn_rst   (syn_rst),
    .tag_in    (tag_in_s),
    .tag_out   (tag_out_s),
    .any_valid (tags_busy_s)
  );

  assign res_data    = unit_out;
  assign a_res_valid = tag_out_s.valid & tag_out_s.id;
  assign b_res_valid = tag_out_s.valid & ~tag_out_s.id;
  assign busy        = (state_r != IDLE) | tags_busy_s;

endmodule

// File: tb/tb_msk_share_arbiter.sv
// Directed bench for msk_share_arbiter (d=2, count=8, LAT=4).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_msk_share_arbiter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         syn_rst;
  logic         a_valid, b_valid, a_last, b_last;
  logic [W-1:0] a_data, b_data, unit_out;
  logic         a_ready, b_ready, unit_valid, a_res_valid, b_res_valid, busy;
  logic [W-1:0] unit_in, res_data;

  int n_cmp = 0;
  int n_bad = 0;

  msk_share_arbiter #(.d(2), .count(8), .LAT(4)) dut (
    .clk         (clk),
    .syn_rst     (syn_rst),
    .a_valid     (a_valid),
    .b_valid     (b_valid),
    .a_last      (a_last),
    .b_last      (b_last),
    .a_data      (a_data),
    .b_data      (b_data),
    .a_ready     (a_ready),
    .b_ready     (b_ready),
    .unit_in     (unit_in),
    .unit_valid  (unit_valid),
    .unit_out    (unit_out),
    .res_data    (res_data),
    .a_res_valid (a_res_valid),
    .b_res_valid (b_res_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  bit exp_a [4];

  initial begin
    syn_rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
    a_data = '0; b_data = '0; unit_out = 16'h5A5A;
    nxt(); nxt();
    syn_rst = 1'b0;
    #1;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_unit_valid", unit_valid, 0);
    chk("rst_res_valid", {a_res_valid, b_res_valid}, 0);
    chk("rst_busy", busy, 0);

    // Single beat from A
    nxt(); a_valid = 1'b1; a_last = 1'b1; a_data = 16'h3CA5; #1;
    chk("sb_c0_a_ready", a_ready, 0);
    nxt(); #1;
    chk("sb_c1_a_ready", a_ready, 1);
    chk("sb_c1_unit_valid", unit_valid, 1);
    chk("sb_c1_unit_in", unit_in, 16'h3CA5);
    nxt(); a_valid = 1'b0; a_last = 1'b0; #1;
    chk("sb_c2_a_ready", a_ready, 0);
    chk("sb_c2_busy", busy, 1);
    nxt(); #1; chk("sb_c3_res", {a_res_valid, b_res_valid}, 2'b00);
    nxt(); #1; chk("sb_c4_res", {a_res_valid, b_res_valid}, 2'b00);
    nxt(); #1;
    chk("sb_c5_res", {a_res_valid, b_res_valid}, 2'b10);
    chk("sb_c5_res_data", res_data, 16'h5A5A);
    nxt(); #1;
    chk("sb_c6_res", {a_res_valid, b_res_valid}, 2'b00);
    chk("sb_c6_busy", busy, 0);

    // Burst lock: A sends 3 beats, B waiting from the second cycle
    nxt(); a_valid = 1'b1; a_last = 1'b0; a_data = 16'h1111; #1;
    chk("bl_c0_a_ready", a_ready, 0);
    nxt(); b_valid = 1'b1; b_last = 1'b1; b_data = 16'hBBBB; #1;
    chk("bl_c1_ready", {a_ready, b_ready}, 2'b10);
    chk("bl_c1_unit_in", unit_in, 16'h1111);
    nxt(); a_data = 16'h2222; #1;
    chk("bl_c2_ready", {a_ready, b_ready}, 2'b10);
    chk("bl_c2_unit_in", unit_in, 16'h2222);
    nxt(); a_data = 16'h3333; a_last = 1'b1; #1;
    chk("bl_c3_ready", {a_ready, b_ready}, 2'b10);
    nxt(); a_valid = 1'b0; a_last = 1'b0; #1;
    chk("bl_c4_ready", {a_ready, b_ready}, 2'b01);
    chk("bl_c4_unit_in", unit_in, 16'hBBBB);
    nxt(); b_valid = 1'b0; b_last = 1'b0; #1;
    chk("bl_c5_ready", {a_ready, b_ready}, 2'b00);
    chk("bl_c5_res", {a_res_valid, b_res_valid}, 2'b10);
    nxt(); #1; chk("bl_c6_res", {a_res_valid, b_res_valid}, 2'b10);
    nxt(); #1; chk("bl_c7_res", {a_res_valid, b_res_valid}, 2'b10);
    nxt(); #1; chk("bl_c8_res", {a_res_valid, b_res_valid}, 2'b01);
    nxt(); #1; chk("bl_c9_busy", busy, 0);

    // Gap in burst: grant held, unit idle and zeroed while A pauses
    nxt(); a_valid = 1'b1; a_last = 1'b0; a_data = 16'h0F0F; #1;
    nxt(); #1;
    chk("gap_c1_unit_in", unit_in, 16'h0F0F);
    nxt(); a_valid = 1'b0; a_data = 16'hF0F0; #1;
    chk("gap_c2_a_ready", a_ready, 1);
    chk("gap_c2_unit_valid", unit_valid, 0);
    chk("gap_c2_unit_in", unit_in, 16'h0000);
    nxt(); #1;
    chk("gap_c3_a_ready", a_ready, 1);
    chk("gap_c3_unit_in", unit_in, 16'h0000);
    nxt(); a_valid = 1'b1; a_last = 1'b1; #1;
    chk("gap_c4_unit_valid", unit_valid, 1);
    chk("gap_c4_unit_in", unit_in, 16'hF0F0);
    nxt(); a_valid = 1'b0; a_last = 1'b0; #1;
    chk("gap_c5_a_ready", a_ready, 0);
    for (int i = 0; i < 6; i++) nxt();

    // Tie-break from reset release, ties always presented in IDLE
`ifdef MSKARB_RR_EN
    exp_a = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_a = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    syn_rst = 1'b1;
    nxt(); syn_rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      a_valid = 1'b1; b_valid = 1'b1; a_last = 1'b1; b_last = 1'b1;
      a_data = 16'hAA00 + 16'(r); b_data = 16'hBB00 + 16'(r); #1;
      chk($sformatf("tie%0d_wait", r), {a_ready, b_ready}, 2'b00);
      nxt();
      if (exp_a[r]) b_valid = 1'b0; else a_valid = 1'b0;
      #1;
      chk($sformatf("tie%0d_grant", r), {a_ready, b_ready}, {exp_a[r], ~exp_a[r]});
      nxt(); a_valid = 1'b0; b_valid = 1'b0; #1;
      chk($sformatf("tie%0d_idle", r), {a_ready, b_ready}, 2'b00);
      nxt();
    end
    for (int i = 0; i < 6; i++) nxt();

    // Reset two cycles after a beat issues: its result is never flagged
    a_valid = 1'b1; a_last = 1'b1; a_data = 16'h7777; #1;
    nxt(); #1;
    chk("rm_c1_unit_valid", unit_valid, 1);
    nxt(); a_valid = 1'b0; a_last = 1'b0; #1;
    chk("rm_c2_busy", busy, 1);
    nxt(); syn_rst = 1'b1; #1;
    nxt(); syn_rst = 1'b0; #1;
    chk("rm_c4_busy", busy, 0);
    chk("rm_c4_ready", {a_ready, b_ready}, 2'b00);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rm_res_%0d", i), {a_res_valid, b_res_valid}, 2'b00);
      nxt(); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
